// File: rtl/uart_cmd_decoder.sv
// Pops UART command bytes from a FWFT RX FIFO and turns R/L/U/D into timed direction pulses.
// Define UART_CMD_LOWERCASE_EN to also accept r/l/u/d as commands.
module uart_cmd_decoder #(
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rd_en,
  output logic       r,
  output logic       l,
  output logic       u,
  output logic       d,
  output logic       cmd_err
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Direction vector is {r, l, u, d}; zero means the byte is not a direction.
  function automatic logic [3:0] decode_dir(input logic [7:0] b);
    logic [3:0] dir;
    case (b)
      8'h52:   dir = 4'b1000;
      8'h4C:   dir = 4'b0100;
      8'h55:   dir = 4'b0010;
      8'h44:   dir = 4'b0001;
`ifdef UART_CMD_LOWERCASE_EN
      8'h72:   dir = 4'b1000;
      8'h6C:   dir = 4'b0100;
      8'h75:   dir = 4'b0010;
      8'h64:   dir = 4'b0001;
`endif
      default: dir = 4'b0000;
    endcase
    return dir;
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       cmd_q, cmd_s;
  logic [3:0]       dir_r, dir_s;
  logic             rd_s, err_s;

  // Next-state, counter and registered-output values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cmd_s   = cmd_q;
    dir_s   = 4'b0000;
    rd_s    = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_empty) begin
          cmd_s = rx_data;
          rd_s  = 1'b1;
          if (decode_dir(rx_data) != 4'b0000) begin
            state_s = PULSE;
            cnt_s   = PULSE_LOAD;
            dir_s   = decode_dir(rx_data);
          end else begin
            state_s = GAP;
            cnt_s   = GAP_LOAD;
            err_s   = !is_eol(rx_data);
          end
        end else begin
          state_s = IDLE;
        end
      end
      PULSE: begin
        // A count of 0 is unreachable; treating it as terminal keeps the FSM from wrapping.
        if (cnt_r <= CNT_ONE) begin
          state_s = GAP;
          cnt_s   = GAP_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
          dir_s = decode_dir(cmd_q);
        end
      end
      GAP: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter, command latch and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cmd_q   <= 8'h00;
      dir_r   <= 4'b0000;
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cmd_q   <= cmd_s;
      dir_r   <= dir_s;
      rd_en   <= rd_s;
      cmd_err <= err_s;
    end
  end

  assign r = dir_r[3];
  assign l = dir_r[2];
  assign u = dir_r[1];
  assign d = dir_r[0];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: a queue-based FIFO plus a timeline reference model.
module tb_uart_cmd_decoder;

  localparam int P = 3;
  localparam int G = 2;
  localparam int TAB = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd_en, r, l, u, d, cmd_err;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_en(rd_en), .r(r), .l(l), .u(u), .d(d), .cmd_err(cmd_err)
  );

  logic [7:0] fifo[$];
  logic [7:0] mq[$];
  // Expected {rd_en, cmd_err, r, l, u, d} for the interval after each rising edge
  logic [5:0] exp_tab [0:TAB-1];
  int cyc, next_edge, errors, checks, rd_seen, err_seen, last_rd, rd_gap;

  // Reference decode: optional case folding, then the four upper-case letters
  function automatic logic [3:0] ref_dir(input logic [7:0] b);
    logic [7:0] c;
    c = b;
`ifdef UART_CMD_LOWERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) c = b - 8'h20;
`endif
    case (c)
      8'h52:   return 4'b1000;
      8'h4C:   return 4'b0100;
      8'h55:   return 4'b0010;
      8'h44:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive();
    rx_empty = (fifo.size() == 0);
    rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    mq.push_back(b);
    drive();
  endtask

  // Byte taken at edge e: timeline of pops, pulses and the earliest next take
  task automatic schedule(input logic [7:0] b, input int e);
    logic [3:0] dir;
    dir = ref_dir(b);
    exp_tab[e][5] = 1'b1;
    if (dir != 4'b0000) begin
      for (int k = 0; k < P; k++) exp_tab[e+k][3:0] = exp_tab[e+k][3:0] | dir;
      next_edge = e + P + G + 1;
    end else begin
      next_edge = e + G + 1;
      if (b != 8'h0D && b != 8'h0A) exp_tab[e][4] = 1'b1;
    end
  endtask

  task automatic step();
    logic [5:0] obs;
    @(posedge clk);
    cyc++;
    if (!reset && cyc >= next_edge && mq.size() > 0) schedule(mq.pop_front(), cyc);
    @(negedge clk);
    obs = {rd_en, cmd_err, r, l, u, d};
    checks++;
    if (obs !== exp_tab[cyc]) begin
      errors++;
      $display("FAIL outputs cyc=%0d got=%b expected=%b ({rd_en,cmd_err,r,l,u,d})", cyc, obs, exp_tab[cyc]);
    end
    checks++;
    if ($countones({r, l, u, d}) > 1) begin
      errors++;
      $display("FAIL onehot cyc=%0d got=%b expected at most one bit set", cyc, {r, l, u, d});
    end
    if (rd_en === 1'b1) begin
      rd_seen++;
      rd_gap  = cyc - last_rd;
      last_rd = cyc;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (cmd_err === 1'b1) err_seen++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int rd0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    rd0 = rd_seen;
    run(20);
    check_int("reset_idle_rd_count", rd_seen - rd0, 0);
  endtask

  task automatic test_single();
    int rd0;
    rd0 = rd_seen;
    push(8'h52);
    run(P + G + 4);
    check_int("single_rd_count", rd_seen - rd0, 1);
    check_int("single_fifo_empty", fifo.size(), 0);
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = rd_seen;
    push(8'h55);
    push(8'h44);
    run(2 * (P + G + 1) + 3);
    check_int("b2b_rd_count", rd_seen - rd0, 2);
    check_int("b2b_rd_spacing", rd_gap, P + G + 1);
  endtask

  task automatic test_crlf_err();
    int rd0, er0;
    rd0 = rd_seen;
    er0 = err_seen;
    push(8'h0D);
    push(8'h0A);
    push(8'h58);
    push(8'h4C);
    run(3 * (G + 1) + (P + G + 1) + 3);
    check_int("crlf_rd_count", rd_seen - rd0, 4);
    check_int("crlf_err_count", err_seen - er0, 1);
  endtask

  task automatic test_lowercase();
    int er0;
    er0 = err_seen;
    push(8'h72);
    run(P + G + 4);
    check_int("lower_err_count", err_seen - er0, (ref_dir(8'h72) == 4'b0000) ? 1 : 0);
  endtask

  task automatic test_reset_mid_pulse();
    int rd0;
    rd0 = rd_seen;
    push(8'h52);
    push(8'h55);
    run(2);
    #1 reset = 1'b1;
    for (int i = cyc + 1; i < cyc + 64; i++) exp_tab[i] = 6'b000000;
    next_edge = 0;
    #1;
    check_int("reset_async_clear", {26'd0, rd_en, cmd_err, r, l, u, d}, 0);
    run(3);
    reset = 1'b0;
    run(P + G + 4);
    check_int("midreset_rd_count", rd_seen - rd0, 2);
    check_int("midreset_fifo_empty", fifo.size(), 0);
  endtask

  task automatic test_random();
    int rd0, pushed;
    logic [7:0] b;
    logic [7:0] dirs [4];
    dirs[0] = 8'h52; dirs[1] = 8'h4C; dirs[2] = 8'h55; dirs[3] = 8'h44;
    rd0 = rd_seen;
    pushed = 0;
    for (int n = 0; n < 120; n++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: b = dirs[$urandom_range(0, 3)];
          5:             b = dirs[$urandom_range(0, 3)] | 8'h20;
          6:             b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
          default:       b = 8'($urandom);
        endcase
        push(b);
        pushed++;
      end
      run($urandom_range(1, 12));
    end
    run((mq.size() + 1) * (P + G + 1) + 5);
    check_int("random_rd_count", rd_seen - rd0, pushed);
    check_int("random_fifo_empty", fifo.size(), 0);
    check_int("random_model_empty", mq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < TAB; i++) exp_tab[i] = 6'b000000;
    cyc = 0; next_edge = 0; errors = 0; checks = 0;
    rd_seen = 0; err_seen = 0; last_rd = 0; rd_gap = 0;
    reset = 1'b1;
    drive();
    test_reset();
    test_single();
    test_back_to_back();
    test_crlf_err();
    test_lowercase();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
